unified_mem_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the IF stage (instruction fetch)
//  and the MEM stage (lw/sw) of the MIPS pipeline. Sequences each access with a req/ack

---
 rtl/unified_mem_arbiter_pkg.sv | 25 ++
 rtl/unified_mem_arbiter_if.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified memory arbiter: FSM states, access owner
// and the registered memory command payload.
package unified_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the IF port, MEM port and memory-side handshake of the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface unified_mem_arbiter_if;
  import unified_mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata, m_ack,
    output if_rdata, if_done, mem_rdata, mem_done, stall, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata, m_ack,
    input  if_rdata, if_done, mem_rdata, mem_done, stall, m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch
// and the MEM stage; MEM wins unless IF has been starved for MAX_MEM_STREAK grants.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  localparam int unsigned           STREAK_W   = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

  state_t              state, state_nxt;
  owner_t              owner, owner_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  mem_cmd_t            cmd, cmd_nxt;
  logic                req, req_nxt;
  logic                if_done_q, if_done_nxt;
  logic                mem_done_q, mem_done_nxt;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_nxt;

  logic mem_any_c;
  logic grant_if_c;

  assign mem_any_c  = bus.mem_rd | bus.mem_wr;
  assign grant_if_c = bus.if_req & (~mem_any_c | (streak == STREAK_MAX));

  // Next-state, command and response logic
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    streak_nxt    = streak;
    req_nxt       = req;
    cmd_nxt       = cmd;
    if_done_nxt   = 1'b0;
    mem_done_nxt  = 1'b0;
    if_rdata_nxt  = if_rdata_q;
    mem_rdata_nxt = mem_rdata_q;

    case (state)
      IDLE: begin
        if (grant_if_c) begin
          owner_nxt     = OWN_IF;
          req_nxt       = 1'b1;
          cmd_nxt.we    = 1'b0;
          cmd_nxt.addr  = bus.if_addr;
          cmd_nxt.wdata = '0;
          streak_nxt    = '0;
          state_nxt     = BUSY;
        end else if (mem_any_c) begin
          owner_nxt     = OWN_MEM;
          req_nxt       = 1'b1;
          // rd+wr together is issued as a store
          cmd_nxt.we    = bus.mem_wr;
          cmd_nxt.addr  = bus.mem_addr;
          cmd_nxt.wdata = bus.mem_wdata;
          if (!bus.if_req) begin
            streak_nxt = '0;
          end else if (streak != STREAK_MAX) begin
            streak_nxt = streak + STREAK_W'(1);
          end
          state_nxt     = BUSY;
        end
      end

      BUSY: begin
        if (bus.m_ack) begin
          req_nxt    = 1'b0;
          cmd_nxt.we = 1'b0;
          state_nxt  = RESP;
          if (owner == OWN_IF) begin
            if_rdata_nxt = bus.m_rdata;
            if_done_nxt  = 1'b1;
          end else begin
            if (!cmd.we) begin
              mem_rdata_nxt = bus.m_rdata;
            end
            mem_done_nxt = 1'b1;
          end
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops m_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      streak      <= '0;
      req         <= 1'b0;
      cmd         <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      streak      <= streak_nxt;
      req         <= req_nxt;
      cmd         <= cmd_nxt;
      if_done_q   <= if_done_nxt;
      mem_done_q  <= mem_done_nxt;
      if_rdata_q  <= if_rdata_nxt;
      mem_rdata_q <= mem_rdata_nxt;
    end
  end

  assign bus.m_req     = req;
  assign bus.m_we      = cmd.we;
  assign bus.m_addr    = cmd.addr;
  assign bus.m_wdata   = cmd.wdata;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  // Pipeline stall until each pending requester sees its done pulse
  assign bus.stall = (bus.if_req & ~if_done_q) | (mem_any_c & ~mem_done_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table, directed corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  localparam int unsigned MAX_STREAK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.MAX_MEM_STREAK(MAX_STREAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        if_req;
    logic        mem_rd;
    logic        mem_wr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_if_done;
    logic        e_mem_done;
    logic        e_stall;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.m_rdata   = '0;
    bus.m_ack     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait for a grant, check the command held for lat cycles, then acknowledge
  task automatic do_access(input string name, input int lat, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we,
                           input logic [31:0] e_wdata);
    int w;
    w = 0;
    while (!bus.m_req && w < 20) begin
      tick();
      w++;
    end
    chk({name, "_grant"}, 32'(bus.m_req), 32'd1);
    chk({name, "_addr"},  bus.m_addr, e_addr);
    chk({name, "_we"},    32'(bus.m_we), 32'(e_we));
    chk({name, "_wdata"}, bus.m_wdata, e_wdata);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({name, "_hold_req"},   32'(bus.m_req), 32'd1);
      chk({name, "_hold_addr"},  bus.m_addr, e_addr);
      chk({name, "_hold_we"},    32'(bus.m_we), 32'(e_we));
      chk({name, "_hold_wdata"}, bus.m_wdata, e_wdata);
    end
    bus.m_ack   = 1'b1;
    bus.m_rdata = rdata;
    tick();
    bus.m_ack   = 1'b0;
    chk({name, "_req_drop"}, 32'(bus.m_req), 32'd0);
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a, input logic [31:0] stored,
                                             input logic hit);
    return hit ? stored : (a ^ 32'h5A5A_0000);
  endfunction

  // Randomized run: model state
  logic [31:0] mem_m [logic [31:0]];
  int          streak_m;
  owner_t      own_m, ack_own;
  logic        inflight, prev_req, ack_store;
  int          lat_cnt, if_age, mem_age;
  logic [31:0] g_addr, g_wdata, exp_rdata, last_load;
  logic        g_we;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();

    // ---------------- reset values ----------------
    do_reset();
    chk("rst_m_req",     32'(bus.m_req), 32'd0);
    chk("rst_m_we",      32'(bus.m_we), 32'd0);
    chk("rst_m_addr",    bus.m_addr, 32'd0);
    chk("rst_m_wdata",   bus.m_wdata, 32'd0);
    chk("rst_if_done",   32'(bus.if_done), 32'd0);
    chk("rst_mem_done",  32'(bus.mem_done), 32'd0);
    chk("rst_if_rdata",  bus.if_rdata, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    chk("rst_stall",     32'(bus.stall), 32'd0);

    // ---------------- vector table: fetch, then MEM-over-IF priority ----------------
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h2001000A, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h2001000A};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8C820004, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h8C820004};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00431020, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h00431020};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};

    bus.if_addr  = 32'h40;
    bus.mem_addr = 32'h100;
    for (int i = 0; i < 9; i++) begin
      bus.if_req  = tbl[i].if_req;
      bus.mem_rd  = tbl[i].mem_rd;
      bus.mem_wr  = tbl[i].mem_wr;
      bus.m_ack   = tbl[i].ack;
      bus.m_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("vec%0d_m_req", i),    32'(bus.m_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_if_done", i),  32'(bus.if_done), 32'(tbl[i].e_if_done));
      chk($sformatf("vec%0d_mem_done", i), 32'(bus.mem_done), 32'(tbl[i].e_mem_done));
      chk($sformatf("vec%0d_stall", i),    32'(bus.stall), 32'(tbl[i].e_stall));
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_m_addr", i), bus.m_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d_m_we", i),   32'(bus.m_we), 32'(tbl[i].e_we));
      end
      if (tbl[i].e_if_done)  chk($sformatf("vec%0d_if_rdata", i),  bus.if_rdata,  tbl[i].e_rdata);
      if (tbl[i].e_mem_done) chk($sformatf("vec%0d_mem_rdata", i), bus.mem_rdata, tbl[i].e_rdata);
    end
    bus.m_ack = 1'b0;

    // ---------------- load then store with 5-cycle memory ----------------
    do_reset();
    bus.mem_rd   = 1'b1;
    bus.mem_addr = 32'h20;
    do_access("ld", 1, 32'h11112222, 32'h20, 1'b0, 32'h0);
    chk("ld_done",  32'(bus.mem_done), 32'd1);
    chk("ld_rdata", bus.mem_rdata, 32'h11112222);
    bus.mem_rd = 1'b0;
    tick();
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'hDEADBEEF;
    do_access("sw", 5, 32'hBAD0BAD0, 32'h10, 1'b1, 32'hDEADBEEF);
    chk("sw_done",      32'(bus.mem_done), 32'd1);
    chk("sw_rdata_keep", bus.mem_rdata, 32'h11112222);
    chk("sw_stall",     32'(bus.stall), 32'd0);
    bus.mem_wr = 1'b0;
    tick();
    chk("sw_done_pulse", 32'(bus.mem_done), 32'd0);

    // ---------------- streak bound: 4 MEM grants then IF, twice ----------------
    do_reset();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h80;
    bus.mem_rd   = 1'b1;
    bus.mem_addr = 32'h200;
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < int'(MAX_STREAK); g++) begin
        do_access($sformatf("streak_mem%0d_%0d", r, g), 1, 32'h1000 + 32'(g), 32'h200, 1'b0, 32'h0);
        chk($sformatf("streak_mem%0d_%0d_done", r, g), 32'(bus.mem_done), 32'd1);
      end
      do_access($sformatf("streak_if%0d", r), 1, 32'h2222, 32'h80, 1'b0, 32'h0);
      chk($sformatf("streak_if%0d_done", r),  32'(bus.if_done), 32'd1);
      chk($sformatf("streak_if%0d_rdata", r), bus.if_rdata, 32'h2222);
    end
    clear_inputs();
    tick();

    // ---------------- reset during BUSY; late ack ignored ----------------
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    tick();
    chk("rstbusy_req_up", 32'(bus.m_req), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstbusy_async_drop", 32'(bus.m_req), 32'd0);
    tick();
    rst        = 1'b0;
    bus.if_req = 1'b0;
    bus.m_ack  = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("late_ack_if_done%0d", i),  32'(bus.if_done), 32'd0);
      chk($sformatf("late_ack_mem_done%0d", i), 32'(bus.mem_done), 32'd0);
      chk($sformatf("late_ack_m_req%0d", i),    32'(bus.m_req), 32'd0);
    end

    // ---------------- rd and wr together = store, one done ----------------
    begin
      int dcount;
      do_reset();
      bus.mem_rd    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = 32'h24;
      bus.mem_wdata = 32'hCAFEF00D;
      do_access("rdwr", 2, 32'h55555555, 32'h24, 1'b1, 32'hCAFEF00D);
      dcount = int'(bus.mem_done);
      chk("rdwr_rdata_keep", bus.mem_rdata, 32'h0);
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        dcount += int'(bus.mem_done);
      end
      chk("rdwr_done_count", 32'(dcount), 32'd1);
    end

    // ---------------- randomized run against transaction-level model ----------------
    do_reset();
    streak_m  = 0;
    own_m     = OWN_IF;
    ack_own   = OWN_IF;
    inflight  = 1'b0;
    prev_req  = 1'b0;
    ack_store = 1'b0;
    lat_cnt   = 0;
    if_age    = 0;
    mem_age   = 0;
    g_addr    = '0;
    g_wdata   = '0;
    g_we      = 1'b0;
    exp_rdata = '0;
    last_load = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_ifd, e_memd, mem_any, e_if;
      tick();

      // responses to the ack that was sampled at this edge
      e_ifd  = bus.m_ack && (ack_own == OWN_IF);
      e_memd = bus.m_ack && (ack_own == OWN_MEM);
      chk("rnd_if_done",  32'(bus.if_done), 32'(e_ifd));
      chk("rnd_mem_done", 32'(bus.mem_done), 32'(e_memd));
      if (e_ifd) chk("rnd_if_rdata", bus.if_rdata, exp_rdata);
      if (e_memd) begin
        if (ack_store) begin
          chk("rnd_store_keep", bus.mem_rdata, last_load);
        end else begin
          chk("rnd_mem_rdata", bus.mem_rdata, exp_rdata);
          last_load = exp_rdata;
        end
      end
      mem_any = bus.mem_rd | bus.mem_wr;
      chk("rnd_stall", 32'(bus.stall),
          32'((bus.if_req && !bus.if_done) || (mem_any && !bus.mem_done)));

      // new grant: decide owner from the priority/starvation rule
      if (bus.m_req && !prev_req) begin
        e_if = bus.if_req && (!mem_any || streak_m == int'(MAX_STREAK));
        if (e_if) begin
          own_m    = OWN_IF;
          g_addr   = bus.if_addr;
          g_we     = 1'b0;
          g_wdata  = 32'h0;
          streak_m = 0;
        end else if (mem_any) begin
          own_m    = OWN_MEM;
          g_addr   = bus.mem_addr;
          g_we     = bus.mem_wr;
          g_wdata  = bus.mem_wdata;
          streak_m = bus.if_req ? ((streak_m < int'(MAX_STREAK)) ? streak_m + 1 : streak_m) : 0;
        end else begin
          chk("rnd_spurious_grant", 32'd1, 32'd0);
        end
        chk("rnd_grant_addr",  bus.m_addr, g_addr);
        chk("rnd_grant_we",    32'(bus.m_we), 32'(g_we));
        chk("rnd_grant_wdata", bus.m_wdata, g_wdata);
        inflight = 1'b1;
        lat_cnt  = int'($urandom_range(0, 3));
      end
      prev_req = bus.m_req;

      // memory model
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
      if (inflight) begin
        if (lat_cnt == 0) begin
          ack_own   = own_m;
          ack_store = (own_m == OWN_MEM) && g_we;
          if (ack_store) begin
            mem_m[g_addr] = g_wdata;
          end else begin
            exp_rdata   = mem_lookup(g_addr, mem_m.exists(g_addr) ? mem_m[g_addr] : 32'h0,
                                     mem_m.exists(g_addr));
            bus.m_rdata = exp_rdata;
          end
          bus.m_ack = 1'b1;
          inflight  = 1'b0;
        end else begin
          lat_cnt--;
        end
      end

      // requesters: hold until done, then maybe issue a new one
      if_age  = (bus.if_req && !bus.if_done) ? if_age + 1 : 0;
      mem_age = (mem_any && !bus.mem_done) ? mem_age + 1 : 0;
      chk("rnd_if_progress",  32'(if_age <= 80), 32'd1);
      chk("rnd_mem_progress", 32'(mem_age <= 80), 32'd1);
      if (if_age > 80) if_age = 0;
      if (mem_age > 80) mem_age = 0;

      if (bus.if_done) begin
        bus.if_req = 1'b0;
      end else if (!bus.if_req && ($urandom % 3) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      if (bus.mem_done) begin
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
      end else if (!mem_any && ($urandom % 3) == 0) begin
        int kind;
        kind          = int'($urandom % 4);
        bus.mem_rd    = (kind != 2);
        bus.mem_wr    = (kind >= 2);
        bus.mem_addr  = 32'($urandom % 16) << 2;
        bus.mem_wdata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
